ifu_rf_rdarb: RTL and testbench
===============================

IFU_RF_RDARB -- requirements
Module: ifu_rf_rdarb

Interface
REQ-001 SHALL have parameter XLEN, default `XLEN, register data width.
REQ-002 SHALL have parameter RFIDX_WIDTH, default `RFIDX_WIDTH, register index width.
REQ-003 SHALL have parameter STARVE_MAX, default 3, the number of consecutive BPU losses that forces a BPU win.
REQ-004 SHALL have ports, one per line:
clk  in  1  sole clock, rising edge.
rst  in  1  reset, asynchronous, active-low.
bpu_req_vld  in  1  BPU jalr rs1 read request.
bpu_req_idx  in  RFIDX_WIDTH  BPU register index.
bpu_req_rdy  out  1  BPU request granted this cycle.
bpu_rsp_vld  out  1  BPU read data valid, one-cycle pulse.
bpu_rsp_dat  out  XLEN  BPU read data.
exu_req_vld  in  1  EXU operand read request.
exu_req_idx  in  RFIDX_WIDTH  EXU register index.
exu_req_rdy  out  1  EXU request granted this cycle.
exu_rsp_vld  out  1  EXU read data valid, one-cycle pulse.
exu_rsp_dat  out  XLEN  EXU read data.
flush  in  1  pipeline flush; kills BPU traffic.
rf_rd_ena  out  1  shared RF read-port enable.
rf_rd_idx  out  RFIDX_WIDTH  shared RF read-port index.
rf_rd_dat  in  XLEN  RF data, valid one cycle after rf_rd_ena.
busy  out  1  a response is pending.

Function
REQ-005 SHALL grant at most one requester per cycle; a grant is rdy=1 while vld=1, combinational from the current vld inputs and the registered state.
REQ-006 SHALL give priority to EXU by default.
REQ-007 SHALL grant BPU instead when both requesters are valid and the starvation counter equals STARVE_MAX.
REQ-008 SHALL increment the starvation counter, saturating at STARVE_MAX, each cycle BPU is valid but not granted.
REQ-009 SHALL clear the starvation counter on a BPU grant, on flush, or when bpu_req_vld=0.
REQ-010 SHALL drive rf_rd_ena=1 and rf_rd_idx=granted index in the grant cycle when the index is nonzero.
REQ-011 SHALL hold rf_rd_ena=0 and rf_rd_idx=0 when no grant occurs or the granted index is 0.
REQ-012 SHALL pulse the granted requester's rsp_vld exactly one cycle after the grant, with rsp_dat=rf_rd_dat, or rsp_dat=0 when the index was 0.
REQ-013 SHALL accept back-to-back grants, one per cycle, with no bubble; throughput is 1 read per cycle.
REQ-014 SHALL hold non-responding rsp_dat at 0.
REQ-015 SHALL apply no response backpressure; consumers accept each rsp_vld pulse.
REQ-016 SHALL keep a response-owner register with values NONE, BPU or EXU, plus a zero-index flag: NONE->BPU/EXU on grant; BPU/EXU->NONE on the next cycle without a grant, otherwise -> the new owner.
REQ-017 SHALL, when flush=1, deassert bpu_req_rdy and suppress any bpu_rsp_vld due in the next cycle (owner BPU->NONE); EXU grants and responses are unaffected.
REQ-018 SHALL, when flush=1 and a BPU response is due in the same cycle, suppress that response.
REQ-019 SHALL drive busy=1 whenever the owner is not NONE.
REQ-020 SHALL require requesters to hold vld and idx stable until rdy; the block does not latch ungranted requests.

Reset
REQ-021 SHALL, with rst=0, asynchronously set owner=NONE, zero flag=0 and starvation counter=0, and drive every output to 0.
REQ-022 SHALL discard any response in flight when reset is asserted mid-operation, emitting no rsp_vld after reset release for a pre-reset grant.
REQ-023 SHALL permit its first grant on the first rising clk edge with rst=1.

Structure
REQ-024 SHALL take XLEN, RFIDX_WIDTH and the owner encoding (2-bit: NONE=0, BPU=1, EXU=2) from the shared defines.v.
REQ-025 SHALL build all state from sirv_gnrl_dfflr-style flops with async active-low reset.
REQ-026 SHALL use one sub-module, ifu_rdarb_starve_cnt, for the saturating starvation counter.

Verification
REQ-027 SHALL pass: BPU-only request, idx=5, rf_rd_dat=0x8000_0040 -> grant cycle N with rf_rd_ena=1 and rf_rd_idx=5; bpu_rsp_vld=1 with dat 0x8000_0040 at N+1.
REQ-028 SHALL pass: BPU and EXU both valid continuously, STARVE_MAX=3 -> EXU granted 3 cycles, BPU granted on the 4th, then EXU again.
REQ-029 SHALL pass: EXU request idx=0 -> rf_rd_ena=0, exu_rsp_vld=1 with dat 0 at the next cycle.
REQ-030 SHALL pass: BPU grant at N, flush=1 at N+1 -> bpu_rsp_vld=0 at N+1, counter 0, busy=0 at N+2.
REQ-031 SHALL pass: EXU grants at N and N+1 with idx 3 then 7 -> rf_rd_idx 3 then 7; two consecutive exu_rsp_vld pulses carrying the matching data.
REQ-032 SHALL pass: rst asserted the cycle after a grant -> no rsp_vld in that or any later cycle, all outputs 0 immediately.

Source files
------------

// File: rtl/ifu_rf_rdarb_pkg.sv
// ---------------------------------------------------------------------------
// ifu_rf_rdarb_pkg
// Shared definitions for the IFU register-file read-port arbiter:
//   - default register data width and register index width
//   - response-owner encoding (NONE=0, BPU=1, EXU=2)
//   - width helper for the BPU starvation counter
// ---------------------------------------------------------------------------
package ifu_rf_rdarb_pkg;

  localparam int DEF_XLEN        = 32;
  localparam int DEF_RFIDX_WIDTH = 5;

  // Which requester owns the response due in the current cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_BPU  = 2'd1,
    OWN_EXU  = 2'd2
  } owner_e;

  // Bits needed to count 0..max_val; at least one bit so that a
  // STARVE_MAX of 0 still yields a legal vector.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ifu_rdarb_starve_cnt.sv
// ---------------------------------------------------------------------------
// ifu_rdarb_starve_cnt
// Saturating counter of consecutive cycles in which the BPU asked for the
// read port but lost it to the EXU.
//   clk    : clock, rising edge
//   rst    : asynchronous reset, active-low
//   clr    : clear to zero (dominates inc)
//   inc    : count one more loss, saturating at STARVE_MAX
//   at_max : counter equals STARVE_MAX, the BPU must win next contest
// ---------------------------------------------------------------------------
module ifu_rdarb_starve_cnt #(
  parameter int STARVE_MAX = 3,
  parameter int CNT_W      = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  logic [CNT_W-1:0] cnt_q;

  assign at_max = (cnt_q == CNT_W'(STARVE_MAX));

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering in simulation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && !at_max) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ifu_rf_rdarb.sv
// ---------------------------------------------------------------------------
// ifu_rf_rdarb
// Arbitrates the single shared register-file read port between the BPU
// (jalr rs1 lookup) and the EXU (operand read). EXU wins by default; after
// STARVE_MAX consecutive BPU losses the BPU wins the next contest. Reads of
// x0 do not touch the RF and return zero. Data returns one cycle after the
// grant on the winner's rsp channel; flush kills BPU grants and any BPU
// response due in the flush cycle.
//   clk                    : clock, rising edge
//   rst                    : asynchronous reset, active-low
//   bpu_req_vld/idx/rdy    : BPU request handshake
//   bpu_rsp_vld/dat        : BPU response, one-cycle pulse
//   exu_req_vld/idx/rdy    : EXU request handshake
//   exu_rsp_vld/dat        : EXU response, one-cycle pulse
//   flush                  : pipeline flush, kills BPU traffic
//   rf_rd_ena/idx          : shared RF read port
//   rf_rd_dat              : RF data, valid one cycle after rf_rd_ena
//   busy                   : a response is pending this cycle
// ---------------------------------------------------------------------------
module ifu_rf_rdarb
  import ifu_rf_rdarb_pkg::*;
#(
  parameter int XLEN        = DEF_XLEN,
  parameter int RFIDX_WIDTH = DEF_RFIDX_WIDTH,
  parameter int STARVE_MAX  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   bpu_req_vld,
  input  logic [RFIDX_WIDTH-1:0] bpu_req_idx,
  output logic                   bpu_req_rdy,
  output logic                   bpu_rsp_vld,
  output logic [XLEN-1:0]        bpu_rsp_dat,
  input  logic                   exu_req_vld,
  input  logic [RFIDX_WIDTH-1:0] exu_req_idx,
  output logic                   exu_req_rdy,
  output logic                   exu_rsp_vld,
  output logic [XLEN-1:0]        exu_rsp_dat,
  input  logic                   flush,
  output logic                   rf_rd_ena,
  output logic [RFIDX_WIDTH-1:0] rf_rd_idx,
  input  logic [XLEN-1:0]        rf_rd_dat,
  output logic                   busy
);

  localparam int CNT_W = cnt_width(STARVE_MAX);

  logic                   starve_at_max;
  logic                   bpu_gnt;
  logic                   exu_gnt;
  logic                   any_gnt;
  logic [RFIDX_WIDTH-1:0] gnt_idx;
  logic                   gnt_idx_zero;
  owner_e                 owner_q;
  owner_e                 owner_d;
  logic                   zero_q;
  logic                   zero_d;

  // Grant selection. Grants are qualified by rst so the handshake outputs
  // read zero while reset is held, even with requests pending.
  // NOTE: every signal assigned in an always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    bpu_gnt = 1'b0;
    exu_gnt = 1'b0;
    gnt_idx = '0;
    if (rst) begin
      if (bpu_req_vld && !flush && (!exu_req_vld || starve_at_max)) begin
        bpu_gnt = 1'b1;
        gnt_idx = bpu_req_idx;
      end else if (exu_req_vld) begin
        exu_gnt = 1'b1;
        gnt_idx = exu_req_idx;
      end
    end
  end

  assign any_gnt      = bpu_gnt | exu_gnt;
  assign gnt_idx_zero = (gnt_idx == '0);

  assign bpu_req_rdy = bpu_gnt;
  assign exu_req_rdy = exu_gnt;

  // x0 is hard-wired zero: skip the RF access and answer from the flag.
  assign rf_rd_ena = any_gnt && !gnt_idx_zero;
  assign rf_rd_idx = rf_rd_ena ? gnt_idx : '0;

  // BPU losses accumulate only while the BPU keeps asking without a flush.
  ifu_rdarb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (CNT_W)
  ) u_starve_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (flush | ~bpu_req_vld | bpu_gnt),
    .inc    (bpu_req_vld & ~bpu_gnt),
    .at_max (starve_at_max)
  );

  // Owner of next cycle's response: a grant this cycle sets it, otherwise
  // it falls back to NONE.
  always_comb begin
    owner_d = OWN_NONE;
    if (bpu_gnt) begin
      owner_d = OWN_BPU;
    end else if (exu_gnt) begin
      owner_d = OWN_EXU;
    end
  end

  assign zero_d = any_gnt && gnt_idx_zero;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q <= OWN_NONE;
      zero_q  <= 1'b0;
    end else begin
      owner_q <= owner_d;
      zero_q  <= zero_d;
    end
  end

  // A flush in the response cycle cancels an outstanding BPU response.
  assign bpu_rsp_vld = (owner_q == OWN_BPU) && !flush;
  assign exu_rsp_vld = (owner_q == OWN_EXU);

  assign bpu_rsp_dat = (bpu_rsp_vld && !zero_q) ? rf_rd_dat : '0;
  assign exu_rsp_dat = (exu_rsp_vld && !zero_q) ? rf_rd_dat : '0;

  assign busy = (owner_q != OWN_NONE);

endmodule

// File: tb/tb_ifu_rf_rdarb.sv
// ---------------------------------------------------------------------------
// tb_ifu_rf_rdarb
// Directed and randomized stimulus for ifu_rf_rdarb, checked cycle by cycle
// against a behavioural model: an integer count of consecutive BPU losses,
// the owner/index of the response due next cycle, and a register-file array
// that answers the DUT's read port one cycle later.
// ---------------------------------------------------------------------------
module tb_ifu_rf_rdarb;

  localparam int XL   = 32;
  localparam int IW   = 5;
  localparam int SMAX = 3;

  logic          clk;
  logic          rst;
  logic          bpu_req_vld;
  logic [IW-1:0] bpu_req_idx;
  logic          bpu_req_rdy;
  logic          bpu_rsp_vld;
  logic [XL-1:0] bpu_rsp_dat;
  logic          exu_req_vld;
  logic [IW-1:0] exu_req_idx;
  logic          exu_req_rdy;
  logic          exu_rsp_vld;
  logic [XL-1:0] exu_rsp_dat;
  logic          flush;
  logic          rf_rd_ena;
  logic [IW-1:0] rf_rd_idx;
  logic [XL-1:0] rf_rd_dat;
  logic          busy;

  int vectors     = 0;
  int miscompares = 0;

  // Register-file stand-in: synchronous read of the index the DUT presented.
  logic [XL-1:0] regs [32];
  logic [IW-1:0] rf_idx_q;

  // Model state: consecutive BPU losses, and the response due next cycle
  // (0 none, 1 BPU, 2 EXU) with the index it reads.
  int losses;
  int pend_who;
  int pend_idx;

  ifu_rf_rdarb #(
    .XLEN        (XL),
    .RFIDX_WIDTH (IW),
    .STARVE_MAX  (SMAX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bpu_req_vld (bpu_req_vld),
    .bpu_req_idx (bpu_req_idx),
    .bpu_req_rdy (bpu_req_rdy),
    .bpu_rsp_vld (bpu_rsp_vld),
    .bpu_rsp_dat (bpu_rsp_dat),
    .exu_req_vld (exu_req_vld),
    .exu_req_idx (exu_req_idx),
    .exu_req_rdy (exu_req_rdy),
    .exu_rsp_vld (exu_rsp_vld),
    .exu_rsp_dat (exu_rsp_dat),
    .flush       (flush),
    .rf_rd_ena   (rf_rd_ena),
    .rf_rd_idx   (rf_rd_idx),
    .rf_rd_dat   (rf_rd_dat),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rf_idx_q <= rf_rd_idx;
  assign rf_rd_dat = regs[rf_idx_q];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "/bpu_req_rdy"}, 64'(bpu_req_rdy), 64'd0);
    check({tag, "/bpu_rsp_vld"}, 64'(bpu_rsp_vld), 64'd0);
    check({tag, "/bpu_rsp_dat"}, 64'(bpu_rsp_dat), 64'd0);
    check({tag, "/exu_req_rdy"}, 64'(exu_req_rdy), 64'd0);
    check({tag, "/exu_rsp_vld"}, 64'(exu_rsp_vld), 64'd0);
    check({tag, "/exu_rsp_dat"}, 64'(exu_rsp_dat), 64'd0);
    check({tag, "/rf_rd_ena"},   64'(rf_rd_ena),   64'd0);
    check({tag, "/rf_rd_idx"},   64'(rf_rd_idx),   64'd0);
    check({tag, "/busy"},        64'(busy),        64'd0);
  endtask

  // One clock cycle: entered just after a rising edge, drives the inputs,
  // checks every output against the model, advances the model and returns
  // just after the next rising edge. bg/eg report the expected grants.
  task automatic cycle(input string tag,
                       input logic bv, input logic [IW-1:0] bi,
                       input logic ev, input logic [IW-1:0] ei,
                       input logic fl,
                       output logic bg, output logic eg);
    logic          e_bresp, e_eresp, e_ena;
    logic [XL-1:0] e_dat;
    logic [IW-1:0] e_idx;
    bpu_req_vld = bv;
    bpu_req_idx = bi;
    exu_req_vld = ev;
    exu_req_idx = ei;
    flush       = fl;
    #2;
    e_bresp = (pend_who == 1) && !fl;
    e_eresp = (pend_who == 2);
    e_dat   = (pend_idx == 0) ? '0 : regs[pend_idx];
    bg      = bv && !fl && (!ev || losses == SMAX);
    eg      = ev && !bg;
    e_idx   = bg ? bi : (eg ? ei : '0);
    e_ena   = (bg || eg) && (e_idx != 0);
    check({tag, "/bpu_req_rdy"}, 64'(bpu_req_rdy), 64'(bg));
    check({tag, "/exu_req_rdy"}, 64'(exu_req_rdy), 64'(eg));
    check({tag, "/rf_rd_ena"},   64'(rf_rd_ena),   64'(e_ena));
    check({tag, "/rf_rd_idx"},   64'(rf_rd_idx),   64'(e_ena ? e_idx : '0));
    check({tag, "/bpu_rsp_vld"}, 64'(bpu_rsp_vld), 64'(e_bresp));
    check({tag, "/bpu_rsp_dat"}, 64'(bpu_rsp_dat), 64'(e_bresp ? e_dat : '0));
    check({tag, "/exu_rsp_vld"}, 64'(exu_rsp_vld), 64'(e_eresp));
    check({tag, "/exu_rsp_dat"}, 64'(exu_rsp_dat), 64'(e_eresp ? e_dat : '0));
    check({tag, "/busy"},        64'(busy),        64'(pend_who != 0));
    if (!bv || fl || bg) losses = 0;
    else if (losses < SMAX) losses = losses + 1;
    pend_who = bg ? 1 : (eg ? 2 : 0);
    pend_idx = int'(e_idx);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic          bg, eg;
    logic          hb, he;
    logic [IW-1:0] hbi, hei;
    int            bpu_wins;

    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = 32'hDEAD_BEEF;  // must never leak out as x0 data
    regs[5] = 32'h8000_0040;
    losses   = 0;
    pend_who = 0;
    pend_idx = 0;

    // Reset held with both requesters asking: every output must be zero.
    rst = 1'b0;
    bpu_req_vld = 1'b1; bpu_req_idx = 5'd4;
    exu_req_vld = 1'b1; exu_req_idx = 5'd6;
    flush = 1'b0;
    #2;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // BPU alone reading x5, then its response.
    cycle("bpu_only", 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, bg, eg);
    check("bpu_only/granted", 64'(bg), 64'd1);
    cycle("bpu_only_rsp", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, bg, eg);

    // Continuous contention: EXU x3, BPU on the 4th, then EXU again.
    bpu_wins = 0;
    for (int i = 0; i < 5; i++) begin
      cycle("contend", 1'b1, 5'd9, 1'b1, 5'd11, 1'b0, bg, eg);
      if (bg) bpu_wins = bpu_wins + i * 10 + 1;
    end
    check("contend/bpu_win_slot", 64'(bpu_wins), 64'd31);
    cycle("contend_tail", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, bg, eg);

    // EXU reads x0: no RF access, zero data next cycle.
    cycle("exu_x0", 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, bg, eg);
    cycle("exu_x0_rsp", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, bg, eg);

    // BPU grant followed by a flush in the response cycle.
    cycle("flush_gnt", 1'b1, 5'd12, 1'b0, 5'd0, 1'b0, bg, eg);
    cycle("flush_rsp", 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, bg, eg);
    cycle("flush_after", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, bg, eg);

    // Flush with both asking at starvation limit: EXU still served.
    for (int i = 0; i < 3; i++) cycle("flush_starve", 1'b1, 5'd2, 1'b1, 5'd8, 1'b0, bg, eg);
    cycle("flush_starve_fl", 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, bg, eg);
    cycle("flush_starve_post", 1'b1, 5'd2, 1'b1, 5'd8, 1'b0, bg, eg);
    cycle("flush_starve_idle", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, bg, eg);

    // Back-to-back EXU reads of x3 then x7.
    cycle("b2b_3", 1'b0, 5'd0, 1'b1, 5'd3, 1'b0, bg, eg);
    cycle("b2b_7", 1'b0, 5'd0, 1'b1, 5'd7, 1'b0, bg, eg);
    cycle("b2b_rsp", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, bg, eg);

    // Randomized traffic; requesters hold vld/idx until granted.
    hb = 1'b0; he = 1'b0; hbi = '0; hei = '0;
    for (int n = 0; n < 400; n++) begin
      if (!hb) begin
        hb  = ($urandom_range(2) != 0);
        hbi = IW'($urandom_range(31));
      end
      if (!he) begin
        he  = ($urandom_range(2) != 0);
        hei = IW'($urandom_range(31));
      end
      cycle("random", hb, hbi, he, hei, ($urandom_range(7) == 0), bg, eg);
      if (bg) hb = 1'b0;
      if (eg) he = 1'b0;
    end
    cycle("random_drain", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, bg, eg);

    // Reset asserted the cycle after a grant: response discarded.
    cycle("rst_gnt", 1'b0, 5'd0, 1'b1, 5'd13, 1'b0, bg, eg);
    rst = 1'b0;
    #1;
    check_all_zero("rst_mid");
    @(posedge clk);
    #1;
    check_all_zero("rst_hold");
    losses   = 0;
    pend_who = 0;
    pend_idx = 0;
    rst = 1'b1;
    cycle("rst_after0", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, bg, eg);
    cycle("rst_after1", 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, bg, eg);
    cycle("rst_after2", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, bg, eg);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
